// File: rtl/top_mul_pipe_hs.sv
// Pipelined signed/unsigned multiplier with valid/ready flow control, bubble collapsing,
// round-half-up right shift and optional saturation to the output width.
module top_mul_pipe_hs #(
   parameter int din0_WIDTH = 8,
   parameter int din1_WIDTH = 8,
   parameter int dout_WIDTH = 16,
   parameter int NUM_STAGE  = 3,
   parameter int SHIFT      = 0,
   parameter int SAT        = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   input  logic                  sgn,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  sat_flag,
   output logic                  busy
);

   localparam int W  = din0_WIDTH + din1_WIDTH + 1;
   // One guard bit so that adding the rounding constant can never wrap.
   localparam int RW = W + 1;
   localparam int CW = ((RW > dout_WIDTH + 1) ? RW : dout_WIDTH + 1) + 1;
   localparam int PW = dout_WIDTH + 1;
   localparam int HS = (SHIFT > 0) ? SHIFT - 1 : 0;

   localparam logic signed [RW-1:0] HALF = $signed(RW'(SHIFT > 0) << HS);
   localparam logic        [CW-1:0] ONE  = CW'(1);
   localparam logic signed [CW-1:0] SMAX = $signed((ONE << (dout_WIDTH - 1)) - ONE);
   localparam logic signed [CW-1:0] SMIN = ~SMAX;
   localparam logic signed [CW-1:0] UMAX = $signed((ONE << dout_WIDTH) - ONE);

   function automatic logic signed [W-1:0] mul_ext(input logic [din0_WIDTH-1:0] a,
                                                   input logic [din1_WIDTH-1:0] b,
                                                   input logic                  s);
      logic signed [W-1:0] ae;
      logic signed [W-1:0] be;
      ae = {{(W - din0_WIDTH){s & a[din0_WIDTH-1]}}, a};
      be = {{(W - din1_WIDTH){s & b[din1_WIDTH-1]}}, b};
      return ae * be;
   endfunction

   function automatic logic signed [RW-1:0] round_shift(input logic signed [W-1:0] p);
      logic signed [RW-1:0] pe;
      logic signed [RW-1:0] sum;
      pe  = {p[W-1], p};
      sum = pe + HALF;
      return sum >>> SHIFT;
   endfunction

   // Returns {clipped, value}.
   function automatic logic [PW-1:0] saturate(input logic signed [RW-1:0] r,
                                              input logic                 s);
      logic signed [CW-1:0] re;
      logic [PW-1:0]        res;
      re  = {{(CW - RW){r[RW-1]}}, r};
      res = {1'b0, re[dout_WIDTH-1:0]};
      if (SAT != 0) begin
         if (s) begin
            if (re > SMAX)      res = {1'b1, SMAX[dout_WIDTH-1:0]};
            else if (re < SMIN) res = {1'b1, SMIN[dout_WIDTH-1:0]};
         end else begin
            if (re > UMAX)      res = {1'b1, UMAX[dout_WIDTH-1:0]};
            else if (re[CW-1])  res = {1'b1, {dout_WIDTH{1'b0}}};
         end
      end
      return res;
   endfunction

   logic [PW-1:0]        res_in;
   logic [NUM_STAGE-1:0] v_q;
   logic [NUM_STAGE-1:0] v_d;
   logic [NUM_STAGE-1:0] v_src;
   logic [NUM_STAGE-1:0] adv;

   always_comb begin
      res_in = saturate(round_shift(mul_ext(din0, din1, sgn)), sgn);
   end

   // A stage may load whenever it is empty or its contents move on this cycle.
   always_comb begin
      adv = '0;
      adv[NUM_STAGE-1] = ~v_q[NUM_STAGE-1] | out_ready;
      for (int k = NUM_STAGE - 2; k >= 0; k--) begin
         adv[k] = ~v_q[k] | adv[k+1];
      end
      v_src    = '0;
      v_src[0] = in_valid;
      for (int k = 1; k < NUM_STAGE; k++) begin
         v_src[k] = v_q[k-1];
      end
      v_d = v_q;
      for (int k = 0; k < NUM_STAGE; k++) begin
         if (adv[k]) v_d[k] = v_src[k];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) v_q <= '0;
      else       v_q <= v_d;
   end

   for (genvar g = 0; g < NUM_STAGE; g++) begin : g_stage
      logic [PW-1:0] pay_src;
      logic [PW-1:0] pay_d;
      logic [PW-1:0] pay_q;

      if (g == 0) begin : g_first
         assign pay_src = res_in;
      end else begin : g_next
         assign pay_src = g_stage[g-1].pay_q;
      end

      always_comb begin
         pay_d = adv[g] ? pay_src : pay_q;
      end

      // Stage g -> stage g+1 boundary; only the output stage is cleared by reset.
      if (g == NUM_STAGE - 1) begin : g_out
         always_ff @(posedge clk or posedge reset) begin
            if (reset) pay_q <= '0;
            else       pay_q <= pay_d;
         end
      end else begin : g_mid
         always_ff @(posedge clk) begin
            pay_q <= pay_d;
         end
      end
   end

   assign in_ready  = adv[0];
   assign out_valid = v_q[NUM_STAGE-1];
   assign busy      = |v_q;
   assign dout      = g_stage[NUM_STAGE-1].pay_q[dout_WIDTH-1:0];
   assign sat_flag  = g_stage[NUM_STAGE-1].pay_q[dout_WIDTH];

endmodule

// File: tb/tb_top_mul_pipe_hs.sv
// Directed bench for top_mul_pipe_hs: default 8x8->16 instance plus an 8-bit
// shifted/saturating instance, covering latency, stalls, bubble fill and async reset.
module tb_top_mul_pipe_hs;

   logic        clk;
   logic        reset;
   logic        in_valid, in_ready, sgn, out_valid, out_ready, sat_flag, busy;
   logic [7:0]  din0, din1;
   logic [15:0] dout;

   logic        in_valid3, in_ready3, sgn3, out_valid3, out_ready3, sat_flag3, busy3;
   logic [7:0]  din0_3, din1_3, dout3;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] t3_a   [5] = '{8'd100, 8'h80, 8'hFD, 8'hFF, 8'h80};
   logic [7:0] t3_b   [5] = '{8'd100, 8'h80, 8'h2B, 8'hFF, 8'h7F};
   logic       t3_s   [5] = '{1'b1,   1'b1,  1'b1,  1'b0,  1'b1};
   logic [7:0] t3_exp [5] = '{8'h4E,  8'h7F, 8'hFF, 8'hFF, 8'h81};
   logic       t3_flg [5] = '{1'b0,   1'b1,  1'b0,  1'b1,  1'b0};

   top_mul_pipe_hs u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .din0(din0), .din1(din1), .sgn(sgn), .out_valid(out_valid),
      .out_ready(out_ready), .dout(dout), .sat_flag(sat_flag), .busy(busy)
   );

   top_mul_pipe_hs #(.dout_WIDTH(8), .SHIFT(7), .SAT(1)) u_dut3 (
      .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
      .din0(din0_3), .din1(din1_3), .sgn(sgn3), .out_valid(out_valid3),
      .out_ready(out_ready3), .dout(dout3), .sat_flag(sat_flag3), .busy(busy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Streams nb beats (din0 = index+1, din1 = m) with optional stall/gap windows and
   // checks in_ready against occupancy, output hold while stalled, order and count.
   task automatic run_stream(input string tg, input int nb, input int st_lo, input int st_hi,
                             input int gp_lo, input int gp_hi, input logic s,
                             input logic [7:0] m);
      int          sent, rcv, a, b;
      logic        acc, prev_stall, saw_block;
      logic [15:0] prev_d;
      logic [15:0] exp_q [$];
      sent = 0; rcv = 0; prev_stall = 1'b0; saw_block = 1'b0; prev_d = '0;
      for (int c = 0; c < 80 && rcv < nb; c++) begin
         out_ready = !(c >= st_lo && c <= st_hi);
         in_valid  = (sent < nb) && !(c >= gp_lo && c <= gp_hi);
         din0      = 8'(sent + 1);
         din1      = m;
         sgn       = s;
         #1;
         chk({tg, "_in_ready"}, in_ready, ((sent - rcv) < 3) || out_ready);
         if (!in_ready) saw_block = 1'b1;
         if (prev_stall) chk({tg, "_hold"}, {out_valid, dout}, {1'b1, prev_d});
         acc = in_valid && in_ready;
         if (acc) begin
            a = sent + 1;
            b = int'(m);
            if (s && b > 127) b = b - 256;
            exp_q.push_back(16'(a * b));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk({tg, "_extra"}, out_valid, 1'b0);
            else chk({tg, "_data"}, dout, exp_q.pop_front());
            rcv++;
         end
         prev_stall = out_valid && !out_ready;
         prev_d     = dout;
         tick();
         if (acc) sent++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk({tg, "_count"}, rcv, nb);
      chk({tg, "_blocked"}, saw_block, 1'b1);
      tick();
      chk({tg, "_idle"}, {busy, out_valid}, 2'b00);
   endtask

   initial begin
      int r;
      int cnt;
      reset = 1'b1;
      in_valid = 1'b0; din0 = '0; din1 = '0; sgn = 1'b0; out_ready = 1'b1;
      in_valid3 = 1'b0; din0_3 = '0; din1_3 = '0; sgn3 = 1'b0; out_ready3 = 1'b1;
      tick();
      tick();
      chk("rst_state", {out_valid, busy, sat_flag, dout}, 19'd0);
      chk("rst_in_ready", in_ready, 1'b1);
      reset = 1'b0;
      tick();

      // T1: -128 * -128, latency three cycles
      in_valid = 1'b1; din0 = 8'h80; din1 = 8'h80; sgn = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("t1_lat1", out_valid, 1'b0);
      tick();
      chk("t1_lat2", out_valid, 1'b0);
      tick();
      chk("t1_valid", out_valid, 1'b1);
      chk("t1_dout", dout, 16'h4000);
      chk("t1_sat", sat_flag, 1'b0);
      tick();
      chk("t1_drain", {out_valid, busy}, 2'b00);

      // T2: same operands, unsigned then signed, back to back
      in_valid = 1'b1; din0 = 8'hFF; din1 = 8'hFF; sgn = 1'b0;
      tick();
      sgn = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk("t2_unsigned", {out_valid, dout}, {1'b1, 16'hFE01});
      tick();
      chk("t2_signed", {out_valid, dout}, {1'b1, 16'h0001});
      tick();

      // T3: 8-bit output, shift 7, saturating
      r = 0;
      for (int c = 0; c < 15 && r < 5; c++) begin
         in_valid3 = (c < 5);
         if (c < 5) begin
            din0_3 = t3_a[c]; din1_3 = t3_b[c]; sgn3 = t3_s[c];
         end
         #1;
         chk("t3_in_ready", in_ready3, 1'b1);
         if (out_valid3) begin
            chk("t3_dout", dout3, t3_exp[r]);
            chk("t3_sat", sat_flag3, t3_flg[r]);
            r++;
         end
         tick();
      end
      in_valid3 = 1'b0;
      chk("t3_count", r, 5);

      // T4: 10 beats with output stalled for cycles 2..6
      run_stream("t4", 10, 2, 6, -1, -1, 1'b0, 8'd3);

      // T5: one beat, two idle cycles, then more beats into a stalled output
      run_stream("t5", 4, 3, 6, 1, 2, 1'b1, 8'hFE);

      // T6: asynchronous reset mid-cycle with two beats in flight
      out_ready = 1'b0; in_valid = 1'b1; din0 = 8'd5; din1 = 8'd6; sgn = 1'b0;
      tick();
      din0 = 8'd7;
      tick();
      in_valid = 1'b0;
      tick();
      chk("t6_pre", {out_valid, busy, dout}, {2'b11, 16'd30});
      #2;
      reset = 1'b1;
      #1;
      chk("t6_async", {out_valid, busy, sat_flag, dout}, 19'd0);
      tick();
      reset = 1'b0;
      out_ready = 1'b1;
      cnt = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (out_valid || busy) cnt++;
      end
      chk("t6_after", cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
